// File: rtl/position_decoder_pkg.sv
// position_decoder_pkg
// Shared definitions for the streaming position-to-one-hot decoder:
//   - POS_W_DEF / OUT_W_DEF : default position code width and vector width
//   - occ_state_t           : occupancy of the 2-entry output buffer
//   - decode_pos()          : (pos, none) -> one-hot vector at default width
package position_decoder_pkg;

  localparam int POS_W_DEF = 3;
  localparam int OUT_W_DEF = 1 << POS_W_DEF;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // A "none" code stands for the all-zero vector; otherwise exactly one bit.
  function automatic logic [OUT_W_DEF-1:0] decode_pos(
    input logic [POS_W_DEF-1:0] pos,
    input logic                 none
  );
    logic [OUT_W_DEF-1:0] vec;
    vec = '0;
    if (!none) vec[pos] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/pos_skid_buffer.sv
// pos_skid_buffer
// Generic 2-entry registered valid/ready buffer. The main register drives the
// output; the skid register catches the one extra word accepted in the cycle
// the downstream stalls, so the upstream sees a registered in_ready and the
// stream keeps full throughput.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_data   [W]       : upstream word
//   out_valid/out_ready : downstream handshake
//   out_data  [W]       : main register, stable while stalled
module pos_skid_buffer
  import position_decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_state_t   state_reg, state_next;
  logic [W-1:0] main_reg, main_next;
  logic [W-1:0] skid_reg, skid_next;
  logic         in_ready_reg, in_ready_next;
  logic         accept, deliver;

  assign accept  = in_valid & in_ready_reg;
  assign deliver = (state_reg != OCC_EMPTY) & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      OCC_EMPTY: begin
        if (accept) begin
          state_next = OCC_ONE;
          main_next  = in_data;
        end
      end
      OCC_ONE: begin
        if (accept && deliver) begin
          // Pass-through: the new word replaces the one leaving.
          main_next = in_data;
        end else if (accept) begin
          state_next = OCC_TWO;
          skid_next  = in_data;
        end else if (deliver) begin
          state_next = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // in_ready_reg is low here, so no accept can happen.
        if (deliver) begin
          state_next = OCC_ONE;
          main_next  = skid_reg;
        end
      end
      default: state_next = OCC_EMPTY;
    endcase
    // Registered ready: high whenever the next state still has a free slot.
    in_ready_next = (state_next != OCC_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= OCC_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != OCC_EMPTY);
  assign out_data  = main_reg;

endmodule

// File: rtl/position_decoder_stream.sv
// position_decoder_stream
// Streaming position-to-one-hot decoder (inverse of a priority encoder).
// Each accepted code (in_pos, in_none) becomes vec = none ? 0 : 1 << pos,
// delivered in strict FIFO order through a 2-entry registered skid buffer.
// Optional feature macro: POS_DECODE_ACCUM_EN adds acc_clear / acc_mask, an
// OR-accumulator of every delivered vector since the last clear.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready       : code handshake (in_ready registered)
//   in_pos [POS_W], in_none : position code, all-zero flag
//   out_valid/out_ready     : vector handshake
//   out_onehot [OUT_W]      : decoded vector
//   acc_clear, acc_mask     : accumulator (macro builds only)
module position_decoder_stream
  import position_decoder_pkg::*;
#(
  parameter  int POS_W = POS_W_DEF,
  localparam int OUT_W = 1 << POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot
`ifdef POS_DECODE_ACCUM_EN
  ,
  input  logic             acc_clear,
  output logic [OUT_W-1:0] acc_mask
`endif
);

  logic [OUT_W-1:0] dec_vec;

  // Default width uses the shared package decoder; other widths build the
  // same rule bit by bit.
  generate
    if (POS_W == POS_W_DEF) begin : g_pkg_decode
      assign dec_vec = decode_pos(in_pos, in_none);
    end else begin : g_gen_decode
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
        localparam logic [POS_W-1:0] IDX = POS_W'(gi);
        assign dec_vec[gi] = !in_none && (in_pos == IDX);
      end
    end
  endgenerate

  pos_skid_buffer #(
    .W (OUT_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_onehot)
  );

`ifdef POS_DECODE_ACCUM_EN
  logic [OUT_W-1:0] acc_reg;
  logic             deliver;

  assign deliver = out_valid & out_ready;

  // Clear takes effect before the OR, so a clear coinciding with a delivery
  // leaves exactly the delivered vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (deliver) begin
      acc_reg <= (acc_clear ? '0 : acc_reg) | out_onehot;
    end else if (acc_clear) begin
      acc_reg <= '0;
    end
  end

  assign acc_mask = acc_reg;
`endif

endmodule

// File: tb/tb_position_decoder_stream.sv
// tb_position_decoder_stream
// Scoreboard bench: the driver pushes the expected vector of every accepted
// code into a queue; the monitor pops and compares on each delivery and also
// checks out_valid / in_ready against the queue occupancy.
// Build with POS_DECODE_ACCUM_EN defined to exercise the accumulator too.
module tb_position_decoder_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_pos;
  logic       in_none;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
`ifdef POS_DECODE_ACCUM_EN
  logic       acc_clear;
  logic [7:0] acc_mask;
  logic [7:0] acc_model;
`endif

  always #5 clk = ~clk;

  position_decoder_stream dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pos     (in_pos),
    .in_none    (in_none),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot)
`ifdef POS_DECODE_ACCUM_EN
    ,
    .acc_clear  (acc_clear),
    .acc_mask   (acc_mask)
`endif
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb_q[$];
  logic       last_acc;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the queue contents at every negedge.
  always @(negedge clk) begin
    logic [7:0] v;
    if (reset) begin
      sb_q.delete();
`ifdef POS_DECODE_ACCUM_EN
      acc_model = 8'h00;
`endif
    end else begin
      check("out_valid", {7'd0, out_valid}, {7'd0, sb_q.size() != 0});
      check("in_ready", {7'd0, in_ready}, {7'd0, sb_q.size() < 2});
`ifdef POS_DECODE_ACCUM_EN
      check("acc_mask", acc_mask, acc_model);
`endif
      if (out_valid && sb_q.size() != 0) begin
        check("out_onehot", out_onehot, sb_q[0]);
        if (out_ready) begin
          v = sb_q.pop_front();
          $display("[TB] deliver %02h", v);
`ifdef POS_DECODE_ACCUM_EN
          acc_model = (acc_clear ? 8'h00 : acc_model) | v;
        end else if (acc_clear) begin
          acc_model = 8'h00;
`endif
        end
`ifdef POS_DECODE_ACCUM_EN
      end else if (acc_clear) begin
        acc_model = 8'h00;
`endif
      end
    end
  end

  // One clock with the current inputs; records whether a code was accepted
  // and queues its expected vector.
  task automatic step();
    logic       will;
    logic [7:0] e;
    @(negedge clk);
    will = in_valid && in_ready && !reset;
    e = in_none ? 8'h00 : (8'h01 << in_pos);
    @(posedge clk);
    #1;
    if (will) begin
      sb_q.push_back(e);
      $display("[TB] accept pos=%0d none=%0d exp=%02h", in_pos, in_none, e);
    end
    last_acc = will;
  endtask

  task automatic push_code(input logic [2:0] p, input logic n);
    int k;
    in_valid = 1'b1;
    in_pos   = p;
    in_none  = n;
    k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 20) begin
      step();
      k++;
    end
    in_valid = 1'b0;
    if (!last_acc) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: code %0d not accepted within 20 cycles", p);
    end
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d entries left", sb_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pos    = 3'd0;
    in_none   = 1'b0;
    out_ready = 1'b1;
`ifdef POS_DECODE_ACCUM_EN
    acc_clear = 1'b0;
    acc_model = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_out_onehot", out_onehot, 8'h00);
    check("reset_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk);
    #1;

    // Single code and none code.
    push_code(3'd5, 1'b0);
    drain();
    push_code(3'd6, 1'b1);
    drain();

    // Streaming 0..7 at full rate.
    for (int i = 0; i < 8; i++) push_code(3'(i), 1'b0);
    drain();

    // Back-pressure: 2 and 3 fit, 4 is held off.
    out_ready = 1'b0;
    push_code(3'd2, 1'b0);
    push_code(3'd3, 1'b0);
    in_valid = 1'b1;
    in_pos   = 3'd4;
    in_none  = 1'b0;
    step();
    check("bp_code4_held", {7'd0, last_acc}, 8'h00);
    step();
    check("bp_code4_held2", {7'd0, last_acc}, 8'h00);
    out_ready = 1'b1;
    push_code(3'd4, 1'b0);
    drain();

    // Reset with two entries buffered.
    out_ready = 1'b0;
    push_code(3'd1, 1'b0);
    push_code(3'd7, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midreset_out_onehot", out_onehot, 8'h00);
    check("midreset_out_valid", {7'd0, out_valid}, 8'h00);
    check("midreset_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) step();

`ifdef POS_DECODE_ACCUM_EN
    // Accumulate: 1, 4, none, then 1 delivered together with a clear.
    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    push_code(3'd1, 1'b0);
    push_code(3'd4, 1'b0);
    push_code(3'd0, 1'b1);
    push_code(3'd1, 1'b0);
    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    step();
    check("acc_final", acc_mask, 8'h02);
`endif

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_pos    = 3'($urandom % 8);
      in_none   = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      reset     = ($urandom % 300) == 0;
`ifdef POS_DECODE_ACCUM_EN
      acc_clear = ($urandom % 16) == 0;
`endif
      step();
    end
    reset = 1'b0;
`ifdef POS_DECODE_ACCUM_EN
    acc_clear = 1'b0;
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
